// File: rtl/digit_loader.sv
// digit_loader: receives BCD key digits from the keypad encoder, assembles a
// M:SS cooking time, validates it and hands it to the countdown timer with a
// one-cycle load_pulse. Key entry and start requests are frozen while the
// magnetron runs.
module digit_loader #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       clear,
    input  logic [3:0] d,
    input  logic       loadn,
    input  logic       lock,
    input  logic       commit,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] mins,
    output logic [1:0] digit_count,
    output logic       entry_ok,
    output logic       load_pulse,
    output logic       key_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENTRY  = 2'd1,
        ST_FULL   = 2'd2,
        ST_LOADED = 2'd3
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] sync_in;
    logic                   prev_reg;
    logic                   sync_out;
    logic                   key_evt;

    logic [3:0] sec_ones_reg, sec_ones_next;
    logic [3:0] sec_tens_reg, sec_tens_next;
    logic [3:0] mins_reg,     mins_next;
    logic [1:0] count_reg,    count_next;
    logic       load_pulse_reg, load_pulse_next;
    logic       key_err_reg,    key_err_next;

    // Decoded requests for this cycle; lock suppresses both silently.
    logic do_commit;
    logic commit_ok;
    logic do_key;
    logic key_valid;
    logic accept;

    // Synchroniser chain input wiring: stage 0 takes loadn, each later stage
    // takes the one before it.
    assign sync_in[0] = loadn;
    generate
        for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
            assign sync_in[gi] = sync_reg[gi-1];
        end
    endgenerate

    assign sync_out = sync_reg[SYNC_STAGES-1];

    // Falling edge of the synchronised strobe; one event per keypress no
    // matter how long loadn is held low.
    assign key_evt = !sync_out && prev_reg;

    // Synchroniser and edge history; both idle high so reset never fakes a key.
    always_ff @(posedge clock) begin
        if (clear) begin
            sync_reg <= '1;
            prev_reg <= 1'b1;
        end else begin
            sync_reg <= sync_in;
            prev_reg <= sync_out;
        end
    end

    assign entry_ok = (count_reg != 2'd0) &&
                      (sec_tens_reg <= 4'd5) &&
                      ((mins_reg | sec_tens_reg | sec_ones_reg) != 4'd0);

    // A commit takes precedence over a key arriving in the same cycle; the
    // key is then discarded.
    assign do_commit = !lock && commit;
    assign commit_ok = do_commit && entry_ok;
    assign do_key    = !lock && !commit && key_evt;
    assign key_valid = (d <= 4'd9);
    assign accept    = do_key && key_valid;

    // State register.
    always_ff @(posedge clock) begin
        if (clear) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state_reg;
        if (commit_ok) begin
            state_next = ST_LOADED;
        end else if (accept) begin
            if (state_reg == ST_LOADED) begin
                state_next = ST_ENTRY;
            end else if (count_reg >= 2'd2) begin
                state_next = ST_FULL;
            end else begin
                state_next = ST_ENTRY;
            end
        end
    end

    // Output and datapath next values: digit shift, count, strobes.
    always_comb begin
        sec_ones_next   = sec_ones_reg;
        sec_tens_next   = sec_tens_reg;
        mins_next       = mins_reg;
        count_next      = count_reg;
        load_pulse_next = 1'b0;
        key_err_next    = 1'b0;
        if (do_commit) begin
            if (entry_ok) begin
                load_pulse_next = 1'b1;
                // A key swallowed by a successful commit is still reported.
                key_err_next    = key_evt;
            end else begin
                key_err_next    = 1'b1;
            end
        end else if (do_key) begin
            if (!key_valid) begin
                key_err_next = 1'b1;
            end else if (state_reg == ST_LOADED) begin
                // Fresh entry after a load: previous time is not carried over.
                mins_next     = 4'd0;
                sec_tens_next = 4'd0;
                sec_ones_next = d;
                count_next    = 2'd1;
            end else begin
                mins_next     = sec_tens_reg;
                sec_tens_next = sec_ones_reg;
                sec_ones_next = d;
                count_next    = (count_reg == 2'd3) ? 2'd3 : count_reg + 2'd1;
            end
        end
    end

    // Digit, count and strobe registers.
    always_ff @(posedge clock) begin
        if (clear) begin
            sec_ones_reg   <= 4'd0;
            sec_tens_reg   <= 4'd0;
            mins_reg       <= 4'd0;
            count_reg      <= 2'd0;
            load_pulse_reg <= 1'b0;
            key_err_reg    <= 1'b0;
        end else begin
            sec_ones_reg   <= sec_ones_next;
            sec_tens_reg   <= sec_tens_next;
            mins_reg       <= mins_next;
            count_reg      <= count_next;
            load_pulse_reg <= load_pulse_next;
            key_err_reg    <= key_err_next;
        end
    end

    assign sec_ones    = sec_ones_reg;
    assign sec_tens    = sec_tens_reg;
    assign mins        = mins_reg;
    assign digit_count = count_reg;
    assign load_pulse  = load_pulse_reg;
    assign key_err     = key_err_reg;

endmodule

// File: tb/tb_digit_loader.sv
// Directed bench for digit_loader: a table of key/commit/clear operations with
// hand-computed results, then hand sequences for latency, lock, coincident
// key+commit, and clear priority.
module tb_digit_loader;

    logic       clock = 1'b0;
    logic       clear;
    logic [3:0] d;
    logic       loadn;
    logic       lock;
    logic       commit;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] mins;
    logic [1:0] digit_count;
    logic       entry_ok;
    logic       load_pulse;
    logic       key_err;

    int checks = 0;
    int errors = 0;

    digit_loader #(.SYNC_STAGES(2)) dut (
        .clock       (clock),
        .clear       (clear),
        .d           (d),
        .loadn       (loadn),
        .lock        (lock),
        .commit      (commit),
        .sec_ones    (sec_ones),
        .sec_tens    (sec_tens),
        .mins        (mins),
        .digit_count (digit_count),
        .entry_ok    (entry_ok),
        .load_pulse  (load_pulse),
        .key_err     (key_err)
    );

    always #5 clock = ~clock;

    localparam int OP_KEY    = 0;
    localparam int OP_COMMIT = 1;
    localparam int OP_CLEAR  = 2;

    typedef struct {
        int         op;
        logic [3:0] val;
        logic [3:0] m;
        logic [3:0] t;
        logic [3:0] o;
        logic [1:0] c;
        logic       ok;
        logic       lp;
        logic       err;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs [NVEC];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_regs(input string tag, input logic [3:0] m, input logic [3:0] t,
                              input logic [3:0] o, input logic [1:0] c, input logic ok);
        check({tag, " mins"}, {4'd0, mins}, {4'd0, m});
        check({tag, " sec_tens"}, {4'd0, sec_tens}, {4'd0, t});
        check({tag, " sec_ones"}, {4'd0, sec_ones}, {4'd0, o});
        check({tag, " count"}, {6'd0, digit_count}, {6'd0, c});
        check({tag, " entry_ok"}, {7'd0, entry_ok}, {7'd0, ok});
    endtask

    // Key press: loadn low 4 cycles; strobes sampled 3 clocks after the fall
    // (when the update lands) and one clock later.
    task automatic press(input logic [3:0] val, output logic err3, output logic lp3,
                         output logic err4);
        d     = val;
        loadn = 1'b0;
        tick(); tick(); tick();
        err3 = key_err;
        lp3  = load_pulse;
        tick();
        err4 = key_err;
        loadn = 1'b1;
        tick(); tick(); tick();
    endtask

    task automatic do_commit(output logic lp1, output logic err1, output logic lp2,
                             output logic err2);
        commit = 1'b1;
        tick();
        commit = 1'b0;
        lp1  = load_pulse;
        err1 = key_err;
        tick();
        lp2  = load_pulse;
        err2 = key_err;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        logic a, b, e, f;
        string tag;

        //            op         val    m     t     o     c     ok    lp    err
        vecs[0]  = '{OP_KEY,    4'd1, 4'd0, 4'd0, 4'd1, 2'd1, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{OP_KEY,    4'd3, 4'd0, 4'd1, 4'd3, 2'd2, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{OP_KEY,    4'd0, 4'd1, 4'd3, 4'd0, 2'd3, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{OP_KEY,    4'd5, 4'd3, 4'd0, 4'd5, 2'd3, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{OP_COMMIT, 4'd0, 4'd3, 4'd0, 4'd5, 2'd3, 1'b1, 1'b1, 1'b0};
        vecs[5]  = '{OP_COMMIT, 4'd0, 4'd3, 4'd0, 4'd5, 2'd3, 1'b1, 1'b1, 1'b0};
        vecs[6]  = '{OP_KEY,    4'd9, 4'd0, 4'd0, 4'd9, 2'd1, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{OP_KEY,    4'd0, 4'd0, 4'd9, 4'd0, 2'd2, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{OP_COMMIT, 4'd0, 4'd0, 4'd9, 4'd0, 2'd2, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{OP_KEY,    4'd1, 4'd9, 4'd0, 4'd1, 2'd3, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{OP_COMMIT, 4'd0, 4'd9, 4'd0, 4'd1, 2'd3, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{OP_KEY,    4'd7, 4'd0, 4'd0, 4'd7, 2'd1, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{OP_KEY,    4'hC, 4'd0, 4'd0, 4'd7, 2'd1, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{OP_KEY,    4'd0, 4'd0, 4'd7, 4'd0, 2'd2, 1'b0, 1'b0, 1'b0};
        vecs[14] = '{OP_COMMIT, 4'd0, 4'd0, 4'd7, 4'd0, 2'd2, 1'b0, 1'b0, 1'b1};
        vecs[15] = '{OP_CLEAR,  4'd0, 4'd0, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{OP_COMMIT, 4'd0, 4'd0, 4'd0, 4'd0, 2'd0, 1'b0, 1'b0, 1'b1};
        vecs[17] = '{OP_KEY,    4'd0, 4'd0, 4'd0, 4'd0, 2'd1, 1'b0, 1'b0, 1'b0};
        vecs[18] = '{OP_COMMIT, 4'd0, 4'd0, 4'd0, 4'd0, 2'd1, 1'b0, 1'b0, 1'b1};
        vecs[19] = '{OP_KEY,    4'd0, 4'd0, 4'd0, 4'd0, 2'd2, 1'b0, 1'b0, 1'b0};
        vecs[20] = '{OP_KEY,    4'd8, 4'd0, 4'd0, 4'd8, 2'd3, 1'b1, 1'b0, 1'b0};
        vecs[21] = '{OP_KEY,    4'hF, 4'd0, 4'd0, 4'd8, 2'd3, 1'b1, 1'b0, 1'b1};

        clear  = 1'b1;
        d      = 4'd0;
        loadn  = 1'b1;
        lock   = 1'b0;
        commit = 1'b0;
        tick(); tick();
        clear = 1'b0;
        tick();
        check_regs("reset", 4'd0, 4'd0, 4'd0, 2'd0, 1'b0);
        check("reset load_pulse", {7'd0, load_pulse}, 8'd0);
        check("reset key_err", {7'd0, key_err}, 8'd0);
        $display("reset done");

        for (int i = 0; i < NVEC; i++) begin
            tag = $sformatf("row%0d", i);
            if (vecs[i].op == OP_KEY) begin
                press(vecs[i].val, a, b, e);
                check({tag, " key_err"}, {7'd0, a}, {7'd0, vecs[i].err});
                check({tag, " load_pulse"}, {7'd0, b}, 8'd0);
                check({tag, " key_err width"}, {7'd0, e}, 8'd0);
            end else if (vecs[i].op == OP_COMMIT) begin
                do_commit(a, b, e, f);
                check({tag, " load_pulse"}, {7'd0, a}, {7'd0, vecs[i].lp});
                check({tag, " key_err"}, {7'd0, b}, {7'd0, vecs[i].err});
                check({tag, " load_pulse width"}, {7'd0, e}, 8'd0);
                check({tag, " key_err width"}, {7'd0, f}, 8'd0);
            end else begin
                do_clear();
                check({tag, " load_pulse"}, {7'd0, load_pulse}, 8'd0);
                check({tag, " key_err"}, {7'd0, key_err}, 8'd0);
                tick();
            end
            check_regs(tag, vecs[i].m, vecs[i].t, vecs[i].o, vecs[i].c, vecs[i].ok);
            $display("%s op=%0d val=%0h -> %0d:%0d%0d count=%0d ok=%0b", tag, vecs[i].op,
                     vecs[i].val, mins, sec_tens, sec_ones, digit_count, entry_ok);
        end

        // Latency: update lands exactly 3 clocks after loadn falls; long hold
        // gives a single event.
        do_clear();
        d     = 4'd4;
        loadn = 1'b0;
        tick(); tick();
        check("latency before", {6'd0, digit_count}, 8'd0);
        tick();
        check("latency count", {6'd0, digit_count}, 8'd1);
        check("latency ones", {4'd0, sec_ones}, 8'd4);
        for (int k = 0; k < 6; k++) tick();
        check("long hold count", {6'd0, digit_count}, 8'd1);
        loadn = 1'b1;
        tick(); tick(); tick();
        $display("latency sequence: count=%0d ones=%0d", digit_count, sec_ones);

        // Lock: keys and commit dropped silently; key pressed under lock and
        // released after it does not register.
        do_clear();
        press(4'd2, a, b, e);
        press(4'd3, a, b, e);
        lock = 1'b1;
        press(4'd5, a, b, e);
        check("lock key_err", {7'd0, a}, 8'd0);
        do_commit(a, b, e, f);
        check("lock load_pulse", {7'd0, a}, 8'd0);
        check("lock commit key_err", {7'd0, b}, 8'd0);
        d     = 4'd6;
        loadn = 1'b0;
        tick(); tick(); tick(); tick();
        lock = 1'b0;
        tick(); tick(); tick();
        loadn = 1'b1;
        tick(); tick(); tick();
        check_regs("lock", 4'd0, 4'd2, 4'd3, 2'd2, 1'b1);
        press(4'd6, a, b, e);
        check_regs("after lock", 4'd2, 4'd3, 4'd6, 2'd3, 1'b1);
        $display("lock sequence: %0d:%0d%0d count=%0d", mins, sec_tens, sec_ones, digit_count);

        // Key event coincident with a successful commit: digit dropped and
        // reported.
        d     = 4'd8;
        loadn = 1'b0;
        tick(); tick();
        commit = 1'b1;
        tick();
        commit = 1'b0;
        check("coincident load_pulse", {7'd0, load_pulse}, 8'd1);
        check("coincident key_err", {7'd0, key_err}, 8'd1);
        tick();
        check("coincident pulse width", {6'd0, load_pulse, key_err}, 8'd0);
        loadn = 1'b1;
        tick(); tick(); tick();
        check_regs("coincident", 4'd2, 4'd3, 4'd6, 2'd3, 1'b1);
        $display("coincident sequence: %0d:%0d%0d", mins, sec_tens, sec_ones);

        // Clear coincident with key event and commit wins over both.
        d     = 4'd2;
        loadn = 1'b0;
        tick(); tick();
        commit = 1'b1;
        clear  = 1'b1;
        loadn  = 1'b1;
        tick();
        commit = 1'b0;
        clear  = 1'b0;
        check_regs("clear prio", 4'd0, 4'd0, 4'd0, 2'd0, 1'b0);
        check("clear prio pulses", {6'd0, load_pulse, key_err}, 8'd0);
        tick();
        check("clear prio pulses next", {6'd0, load_pulse, key_err}, 8'd0);
        check("clear prio count next", {6'd0, digit_count}, 8'd0);
        $display("clear sequence: count=%0d", digit_count);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/digit_loader.md
Name: digit_loader

Overview:
- Receiving end of the keypad digit interface: accepts the BCD digit `d` and its active-low strobe `loadn` from the keypad encoder.
- Assembles keystrokes into a M:SS cooking-time entry and validates it.
- On a start request, hands the entry to the countdown timer with a one-cycle `load_pulse`.
- Sits between the keypad encoder and the timer/decoder path. Ignores keys while the magnetron runs.

Parameters:
- SYNC_STAGES, 2, number of flops synchronising `loadn` (minimum 1).

Ports:
- clock  input  1  system clock, all logic on rising edge
- clear  input  1  synchronous, active-high reset; also the user "clear" function
- d  input  4  BCD digit from keypad encoder; stable while `loadn` is low
- loadn  input  1  active-low key strobe; one low period per keypress
- lock  input  1  high while the magnetron is on; freezes entry
- commit  input  1  single-cycle start request
- sec_ones  output  4  entered seconds-ones digit
- sec_tens  output  4  entered seconds-tens digit
- mins  output  4  entered minutes digit
- digit_count  output  2  digits held, 0..3
- entry_ok  output  1  combinational from registers: digit_count!=0, sec_tens<=5, and any digit nonzero
- load_pulse  output  1  one-cycle strobe; sec_ones/sec_tens/mins are valid to the timer in this cycle
- key_err  output  1  one-cycle error strobe

Behaviour:
- Reset (`clear`=1 at a rising edge) has priority over everything:
  - digits 0, digit_count 0, load_pulse 0, key_err 0, state IDLE
  - sync flops and edge-history flop set to 1
- Edge detection:
  - `loadn` passes through SYNC_STAGES flops; `key_evt` = sync_out==0 && prev==1.
  - `d` is sampled unsynchronised in the `key_evt` cycle.
  - Digit registers update at the next edge, so latency is SYNC_STAGES+1 clocks from `loadn` falling to the output change.
  - A `loadn` held low produces exactly one event.
- States:
  - IDLE: count 0.
  - ENTRY: count 1..2.
  - FULL: count 3.
  - LOADED: entry transferred to the timer.
- Digit accept, when `key_evt`, `lock`=0 and `d`<=9:
  - mins<=sec_tens, sec_tens<=sec_ones, sec_ones<=d, count=min(count+1,3).
  - IDLE/ENTRY go to ENTRY, or FULL when the count reaches 3.
  - In FULL, a further digit still shifts: the old mins digit is discarded, count stays 3.
  - From LOADED, the first digit starts a fresh entry: registers treated as zero, so mins=sec_tens=0, sec_ones=d, count 1, state ENTRY.
- Invalid digit: `key_evt` with `d`>9 and `lock`=0. Registers unchanged, key_err=1 for one cycle.
- Commit, when `commit`=1 and `lock`=0:
  - If entry_ok=1: load_pulse=1 next cycle, digits held, state LOADED, digit_count unchanged.
  - If entry_ok=0 (empty, all zero, or sec_tens>5): no load_pulse, key_err=1 for one cycle, state and digits unchanged.
  - Commit in LOADED with entry_ok=1 re-issues load_pulse (restart of the same time).
- Lock: while `lock`=1, key events and commit are silently dropped (no key_err, no change).
  - The edge history keeps tracking, so a key pressed during lock and released after it does not register.
- Simultaneous `key_evt` and `commit`: commit is processed and the digit is discarded; key_err=1 on that cycle only if the commit itself succeeded (the dropped key is reported).
- Outputs: all registered except entry_ok; load_pulse and key_err are never high longer than one cycle per event.

Test Plan:
- Reset, then keys 1,3,0 (each `loadn` low 4 cycles), SYNC_STAGES=2 -> after 3rd key mins=1, sec_tens=3, sec_ones=0, count=3, entry_ok=1; each update lands 3 clocks after `loadn` falls.
- Keys 1,3,0,5 -> mins=3, sec_tens=0, sec_ones=5, count 3 (oldest dropped); commit -> load_pulse high exactly 1 cycle, state LOADED.
- Keys 9,0 (sec_tens=9, sec_ones=0) then commit -> no load_pulse, key_err 1 cycle, digits unchanged; press 1 -> 9,0,1 gives mins=9, sec_tens=0, sec_ones=1; commit -> load_pulse.
- After a load, press 7 -> mins=0, sec_tens=0, sec_ones=7, count=1, no stale digits; `d`=4'hC strobe -> key_err pulse, registers unchanged.
- `lock`=1, press 5 and commit -> no change, no pulses; `lock`=0 while `loadn` still low -> no event; next press registers.
- `clear` asserted mid-entry coincident with `key_evt` and `commit` -> all outputs 0 next cycle, state IDLE, no load_pulse or key_err.
